// File: rtl/risc32_stage_reg.sv
// risc32_stage_reg: parametrised inter-stage pipeline register for the risc32 core.
// Carries a payload of control (write-enable) bits and data bits, tracks a
// valid bit, squashes on flush or stall-bubble, and keeps saturating stall and
// bubble performance counters.
//
// Ports:
//   clk          core clock, all state changes on rising edge
//   rst          asynchronous active-low reset
//   stall        stall vector; stall[STAGE] freezes this register,
//                stall[STAGE+1] freezes the downstream stage
//   flush        exception/ERET flush, squashes this stage
//   valid_i      upstream slot holds a real instruction
//   ctrl_i       upstream control / write-enable bits
//   data_i       upstream payload data
//   cnt_clr      synchronous clear of both counters
//   valid_o      registered valid
//   ctrl_o       registered control bits
//   data_o       registered payload data
//   stall_cnt_o  cycles spent holding (saturating)
//   bubble_cnt_o bubbles inserted, stall bubbles plus flushes (saturating)
//
// STAGE+1 must be a legal index into stall (STAGE+1 < STALL_W).
module risc32_stage_reg #(
  parameter int unsigned STAGE               = 4,
  parameter int unsigned STALL_W             = 6,
  parameter int unsigned CTRL_W              = 4,
  parameter int unsigned DATA_W              = 128,
  parameter int unsigned ZERO_DATA_ON_BUBBLE = 1,
  parameter int unsigned CNT_W               = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               valid_i,
  input  logic [CTRL_W-1:0]  ctrl_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               cnt_clr,
  output logic               valid_o,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  localparam int unsigned SELF_IDX = STAGE;
  localparam int unsigned DOWN_IDX = STAGE + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic stall_self;
  logic stall_down;
  logic squash;
  logic hold;

  // Action decode: flush beats everything; a frozen stage with a moving
  // downstream must emit a bubble. stall_down without stall_self is treated
  // as a plain capture.
  assign stall_self = stall[SELF_IDX];
  assign stall_down = stall[DOWN_IDX];
  assign squash     = flush | (stall_self & ~stall_down);
  assign hold       = ~flush & stall_self & stall_down;

  // Next-state for payload and counters.
  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (squash) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (ZERO_DATA_ON_BUBBLE != 0) begin
        data_d = '0;
      end
    end else if (!stall_self) begin
      valid_d = valid_i;
      // An invalid slot never carries a live write enable.
      ctrl_d  = valid_i ? ctrl_i : '0;
      data_d  = data_i;
    end

    // Clear wins over a same-cycle increment; counters saturate, never wrap.
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (hold && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (squash && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      data_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign ctrl_o       = ctrl_q;
  assign data_o       = data_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_risc32_stage_reg.sv
// Bench for risc32_stage_reg. Three instances share the stimulus:
//   0: defaults (zero data on bubble, 16-bit counters)
//   1: keep data on bubble
//   2: 4-bit counters (saturation)
module tb_risc32_stage_reg;

  localparam int NI = 3;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         valid_i;
  logic [3:0]   ctrl_i;
  logic [127:0] data_i;
  logic         cnt_clr;

  logic         o_valid [NI];
  logic [3:0]   o_ctrl  [NI];
  logic [127:0] o_data  [NI];
  logic [15:0]  o_scnt  [NI];
  logic [15:0]  o_bcnt  [NI];
  logic [3:0]   sat_scnt, sat_bcnt;

  // Reference model state per instance.
  logic         m_valid [NI];
  logic [3:0]   m_ctrl  [NI];
  logic [127:0] m_data  [NI];
  int           m_scnt  [NI];
  int           m_bcnt  [NI];
  int           cnt_max [NI];
  bit           zero_bub[NI];

  int n_cmp;
  int n_err;

  risc32_stage_reg u_dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .cnt_clr(cnt_clr),
    .valid_o(o_valid[0]), .ctrl_o(o_ctrl[0]), .data_o(o_data[0]),
    .stall_cnt_o(o_scnt[0]), .bubble_cnt_o(o_bcnt[0])
  );

  risc32_stage_reg #(.ZERO_DATA_ON_BUBBLE(0)) u_dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .cnt_clr(cnt_clr),
    .valid_o(o_valid[1]), .ctrl_o(o_ctrl[1]), .data_o(o_data[1]),
    .stall_cnt_o(o_scnt[1]), .bubble_cnt_o(o_bcnt[1])
  );

  risc32_stage_reg #(.CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .cnt_clr(cnt_clr),
    .valid_o(o_valid[2]), .ctrl_o(o_ctrl[2]), .data_o(o_data[2]),
    .stall_cnt_o(sat_scnt), .bubble_cnt_o(sat_bcnt)
  );

  assign o_scnt[2] = 16'(sat_scnt);
  assign o_bcnt[2] = 16'(sat_bcnt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_valid[i] = 1'b0;
      m_ctrl[i]  = 4'h0;
      m_data[i]  = '0;
      m_scnt[i]  = 0;
      m_bcnt[i]  = 0;
    end
  endtask

  // One rising edge, then apply the pipeline-register rules to the model
  // using the inputs present at that edge; returns 1 ns after the edge.
  task automatic tick();
    bit is_flush, frozen, down_moving;
    @(posedge clk);
    is_flush    = flush;
    frozen      = stall[4];
    down_moving = !stall[5];
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        if (is_flush || (frozen && down_moving)) begin
          m_valid[i] = 1'b0;
          m_ctrl[i]  = 4'h0;
          if (zero_bub[i]) m_data[i] = '0;
          if (!cnt_clr) m_bcnt[i] = (m_bcnt[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_bcnt[i] + 1;
        end else if (!frozen) begin
          m_valid[i] = valid_i;
          m_ctrl[i]  = valid_i ? ctrl_i : 4'h0;
          m_data[i]  = data_i;
        end else begin
          if (!cnt_clr) m_scnt[i] = (m_scnt[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_scnt[i] + 1;
        end
        if (cnt_clr) begin
          m_scnt[i] = 0;
          m_bcnt[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    stall   = 6'b0;
    flush   = 1'b0;
    valid_i = 1'b1;
    ctrl_i  = 4'hF;
    data_i  = '1;
    cnt_clr = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (o_valid[i] !== 1'b0 || o_ctrl[i] !== 4'h0 || o_data[i] !== 128'h0 ||
            o_scnt[i] !== 16'h0 || o_bcnt[i] !== 16'h0) begin
          n_err++;
          $display("FAIL reset[%0d] cyc%0d: got v=%0b c=%0h d=%0h s=%0d b=%0d, want all zero",
                   i, c, o_valid[i], o_ctrl[i], o_data[i], o_scnt[i], o_bcnt[i]);
        end
      end
      if (c < 2) tick();
    end
    // Release at a falling edge, then capture the first word.
    @(negedge clk);
    rst     = 1'b1;
    ctrl_i  = 4'b0101;
    data_i  = 128'h1234;
    tick();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (o_valid[i] !== 1'b1 || o_ctrl[i] !== 4'b0101 || o_data[i] !== 128'h1234) begin
        n_err++;
        $display("FAIL capture[%0d]: got v=%0b c=%0h d=%0h, want v=1 c=5 d=1234",
                 i, o_valid[i], o_ctrl[i], o_data[i]);
      end
    end
  endtask

  task automatic test_hold();
    stall = 6'b110000;
    for (int c = 0; c < 3; c++) begin
      data_i = rand128();
      ctrl_i = 4'($urandom);
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (o_data[i] !== 128'h1234 || o_valid[i] !== 1'b1 || o_ctrl[i] !== 4'b0101 ||
          o_scnt[i] !== 16'd3 || o_bcnt[i] !== 16'd0) begin
        n_err++;
        $display("FAIL hold[%0d]: got v=%0b c=%0h d=%0h s=%0d b=%0d, want v=1 c=5 d=1234 s=3 b=0",
                 i, o_valid[i], o_ctrl[i], o_data[i], o_scnt[i], o_bcnt[i]);
      end
    end
  endtask

  task automatic test_bubble();
    logic [127:0] want;
    stall = 6'b010000;
    tick();
    for (int i = 0; i < NI; i++) begin
      want = zero_bub[i] ? 128'h0 : 128'h1234;
      n_cmp++;
      if (o_valid[i] !== 1'b0 || o_ctrl[i] !== 4'h0 || o_data[i] !== want ||
          o_bcnt[i] !== 16'd1 || o_scnt[i] !== 16'd3) begin
        n_err++;
        $display("FAIL bubble[%0d]: got v=%0b c=%0h d=%0h s=%0d b=%0d, want v=0 c=0 d=%0h s=3 b=1",
                 i, o_valid[i], o_ctrl[i], o_data[i], o_scnt[i], o_bcnt[i], want);
      end
    end
  endtask

  task automatic test_flush_beats_stall();
    logic [127:0] want;
    logic [127:0] loaded;
    // Reload a live word first so the flush has something to squash.
    stall   = 6'b0;
    valid_i = 1'b1;
    ctrl_i  = 4'b1010;
    loaded  = rand128();
    data_i  = loaded;
    tick();
    stall = 6'b110000;
    flush = 1'b1;
    data_i = rand128();
    tick();
    flush = 1'b0;
    for (int i = 0; i < NI; i++) begin
      want = zero_bub[i] ? 128'h0 : loaded;
      n_cmp++;
      if (o_valid[i] !== 1'b0 || o_ctrl[i] !== 4'h0 || o_data[i] !== want ||
          o_scnt[i] !== 16'd3 || o_bcnt[i] !== 16'd2) begin
        n_err++;
        $display("FAIL flush[%0d]: got v=%0b c=%0h d=%0h s=%0d b=%0d, want v=0 c=0 d=%0h s=3 b=2",
                 i, o_valid[i], o_ctrl[i], o_data[i], o_scnt[i], o_bcnt[i], want);
      end
    end
  endtask

  task automatic test_invalid_capture();
    logic [127:0] d;
    stall   = 6'b0;
    valid_i = 1'b0;
    ctrl_i  = 4'hF;
    d       = rand128();
    data_i  = d;
    tick();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (o_valid[i] !== 1'b0 || o_ctrl[i] !== 4'h0 || o_data[i] !== d) begin
        n_err++;
        $display("FAIL invalid_cap[%0d]: got v=%0b c=%0h d=%0h, want v=0 c=0 d=%0h",
                 i, o_valid[i], o_ctrl[i], o_data[i], d);
      end
    end
    valid_i = 1'b1;
  endtask

  task automatic test_saturation_clear();
    stall = 6'b110000;
    for (int c = 0; c < 20; c++) tick();
    n_cmp++;
    if (o_scnt[2] !== 16'd15) begin
      n_err++;
      $display("FAIL sat_stall: got %0d want 15", o_scnt[2]);
    end
    n_cmp++;
    if (o_scnt[0] !== 16'(m_scnt[0])) begin
      n_err++;
      $display("FAIL wide_stall: got %0d want %0d", o_scnt[0], m_scnt[0]);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (o_scnt[i] !== 16'd0 || o_bcnt[i] !== 16'd0) begin
        n_err++;
        $display("FAIL clear[%0d]: got s=%0d b=%0d want 0 0", i, o_scnt[i], o_bcnt[i]);
      end
    end
    tick();
    n_cmp++;
    if (o_scnt[2] !== 16'd1) begin
      n_err++;
      $display("FAIL resume: got %0d want 1", o_scnt[2]);
    end
    // Asynchronous reset in the middle of a hold cycle.
    tick();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (o_valid[i] !== 1'b0 || o_ctrl[i] !== 4'h0 || o_data[i] !== 128'h0 ||
          o_scnt[i] !== 16'h0 || o_bcnt[i] !== 16'h0) begin
        n_err++;
        $display("FAIL async_rst[%0d]: got v=%0b c=%0h d=%0h s=%0d b=%0d, want all zero",
                 i, o_valid[i], o_ctrl[i], o_data[i], o_scnt[i], o_bcnt[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      stall   = {4'($urandom), 4'b0} & 6'b110000;
      flush   = ($urandom_range(0, 7) == 0);
      valid_i = $urandom_range(0, 1) == 1;
      ctrl_i  = 4'($urandom);
      data_i  = rand128();
      cnt_clr = ($urandom_range(0, 31) == 0);
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (o_valid[i] !== m_valid[i] || o_ctrl[i] !== m_ctrl[i] || o_data[i] !== m_data[i] ||
            o_scnt[i] !== 16'(m_scnt[i]) || o_bcnt[i] !== 16'(m_bcnt[i])) begin
          n_err++;
          $display("FAIL random[%0d] cyc%0d: got v=%0b c=%0h d=%0h s=%0d b=%0d, want v=%0b c=%0h d=%0h s=%0d b=%0d",
                   i, c, o_valid[i], o_ctrl[i], o_data[i], o_scnt[i], o_bcnt[i],
                   m_valid[i], m_ctrl[i], m_data[i], m_scnt[i], m_bcnt[i]);
        end
      end
      #1;
    end
    cnt_clr = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cnt_max[0] = 65535; zero_bub[0] = 1'b1;
    cnt_max[1] = 65535; zero_bub[1] = 1'b0;
    cnt_max[2] = 15;    zero_bub[2] = 1'b1;
    test_reset();
    test_hold();
    test_bubble();
    test_flush_beats_stall();
    test_invalid_capture();
    test_saturation_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
